bus_share_arbiter: RTL and testbench
====================================

Name: bus_share_arbiter

Overview:
Two-requester round-robin arbiter that shares the 8-bit operand path built from mux2x1 between two datapath sources, e.g. register-file read port and immediate/forwarding unit.
Grants ownership, drives the mux SELECT line and registers the selected byte onto a shared output bus.
Holds a grant while the owner keeps requesting, and pre-empts it after MAX_HOLD cycles under contention.

Parameters:
MAX_HOLD, 4, maximum consecutive ownership cycles when the other requester is waiting; legal range 1..255.

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  synchronous, active-high reset.
REQ0  input  1  requester 0 wants the bus; level, held until done.
REQ1  input  1  requester 1 wants the bus.
DATA0  input  8  requester 0 operand; valid while GNT0=1.
DATA1  input  8  requester 1 operand; valid while GNT1=1.
GNT0  output  1  registered grant to requester 0.
GNT1  output  1  registered grant to requester 1.
SELECT  output  1  mux select: 0 = DATA0, 1 = DATA1.
BUSOUT  output  8  registered shared-bus byte.
BUSVALID  output  1  BUSOUT holds granted data this cycle.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RESET). All state updates on the rising edge of CLK.
- Reset values: state=IDLE, GNT0=0, GNT1=0, SELECT=0, BUSOUT=8'h00, BUSVALID=0, HOLD=0, LAST=1. LAST=1 means requester 0 wins the first contention.
- Reset mid-grant: all grants drop at that edge. No partial-state carry-over.
- States: IDLE, OWN0, OWN1. GNT0=(state==OWN0), GNT1=(state==OWN1). At most one grant is ever high.
- IDLE transitions:
  - REQ0&REQ1 -> owner is the requester != LAST.
  - REQ0 only -> OWN0.
  - REQ1 only -> OWN1.
  - neither -> stay IDLE.
  - Grant latency: 1 cycle from REQ sampled high.
- OWNx, HOLD counter (8-bit):
  - HOLD is cleared on entry to OWNx.
  - HOLD increments each owned cycle and saturates at MAX_HOLD-1.
- OWNx release conditions, evaluated every cycle:
  - (a) REQx=0.
  - (b) HOLD==MAX_HOLD-1 and REQy=1 (pre-empt).
- On release: LAST<=x. Next state is OWNy if REQy=1, else IDLE.
  - Handoff to OWNy is direct, with no idle cycle between grants.
- No release while REQx=1 and REQy=0. Ownership is unlimited without contention.
- MAX_HOLD=1: strict alternation every cycle under sustained contention.
- SELECT: registered with state. 0 in OWN0, 1 in OWN1; holds its previous value in IDLE.
- Data path: each cycle with GNTx=1, BUSOUT<=DATAx (via SELECT) and BUSVALID<=1. Otherwise BUSVALID<=0 and BUSOUT holds.
  - Data latency: BUSOUT valid 1 cycle after the GNT cycle in which DATA was presented.
- A requester dropping REQ in the same cycle its grant arrives still gets that grant cycle. Its DATA is captured once, then the grant is released.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs GCOUNT0 and GCOUNT1 (8-bit each).
  - A counter increments on every transition into OWN0 / OWN1 respectively, including direct handoffs.
  - Counters saturate at 8'hFF and clear on RESET.
- Undefined: no counters, no extra ports. Core behaviour is identical either way.

Test Plan:
1. RESET 2 cycles, then REQ0=1, DATA0=8'hA5 -> GNT0=1 next edge, SELECT=0; BUSOUT=8'hA5 and BUSVALID=1 one cycle later; REQ0=0 -> GNT0=0 next edge, then IDLE.
2. After reset, REQ0=REQ1=1 held, DATA0=8'h11, DATA1=8'h22, MAX_HOLD=4 -> GNT0 for 4 cycles, then GNT1 for 4 cycles, alternating with no idle gap; BUSOUT follows 11,11,11,11,22,22,22,22 lagging one cycle; SELECT toggles 0->1.
3. REQ1 alone held 10 cycles -> GNT1 high all 10 cycles (no pre-emption); HOLD saturates at 3.
4. GNT0 owned, REQ1=1 pending, REQ0 drops after 2 owned cycles -> GNT1 asserted on the next edge; LAST=0, so a following simultaneous request goes to requester 1.
5. RESET asserted while GNT1=1 and BUSVALID=1 -> next edge: GNT1=0, BUSVALID=0, SELECT=0, BUSOUT=8'h00; then REQ0=REQ1=1 -> GNT0 first.
6. ARB_STATS_EN defined, MAX_HOLD=1, both requesting 600 cycles -> GCOUNT0=GCOUNT1=8'hFF (saturated); with the macro undefined the same stimulus gives an identical GNT/BUSOUT trace.

Source files
------------

// File: rtl/bus_share_arbiter_if.sv
// bus_share_arbiter_if
// Groups the requester-side handshake and the shared-bus outputs of
// bus_share_arbiter.
//
// Handshake: REQx is a level held high for as long as requester x wants the
// bus. GNTx is registered and rises one cycle after REQx is sampled high.
// DATAx must be valid during every cycle that GNTx=1. BUSOUT and BUSVALID
// present that byte one cycle later. There is no back-pressure: a granted
// requester owns the bus until it drops REQx or is pre-empted.
//
// Signals
//   REQ0, REQ1     requester -> arbiter  bus request levels
//   DATA0, DATA1   requester -> arbiter  8-bit operands
//   GNT0, GNT1     arbiter -> requester  registered grants (one-hot or zero)
//   SELECT         arbiter -> requester  mux select (0 = DATA0, 1 = DATA1)
//   BUSOUT         arbiter -> requester  registered shared-bus byte
//   BUSVALID       arbiter -> requester  BUSOUT carries granted data
//   state_dbg      FSM state (0 = IDLE, 1 = OWN0, 2 = OWN1)
//   hold_dbg       consecutive-ownership counter
//   last_dbg       requester that most recently released ownership
//
// Modports: master = requester/bench side, slave = arbiter side.
interface bus_share_arbiter_if;
  logic       REQ0;
  logic       REQ1;
  logic [7:0] DATA0;
  logic [7:0] DATA1;
  logic       GNT0;
  logic       GNT1;
  logic       SELECT;
  logic [7:0] BUSOUT;
  logic       BUSVALID;
  logic [1:0] state_dbg;
  logic [7:0] hold_dbg;
  logic       last_dbg;

  modport master (
    output REQ0, REQ1, DATA0, DATA1,
    input  GNT0, GNT1, SELECT, BUSOUT, BUSVALID,
    input  state_dbg, hold_dbg, last_dbg
  );

  modport slave (
    input  REQ0, REQ1, DATA0, DATA1,
    output GNT0, GNT1, SELECT, BUSOUT, BUSVALID,
    output state_dbg, hold_dbg, last_dbg
  );
endinterface

// File: rtl/bus_share_arbiter.sv
// bus_share_arbiter
// Two-requester round-robin arbiter for a shared 8-bit operand path. It grants
// ownership, drives the 2:1 mux select and registers the selected byte onto
// the shared bus. An owner keeps the bus while it requests. When the other
// requester is waiting, the owner is pre-empted after MAX_HOLD cycles.
//
// Ports
//   CLK        system clock, rising edge
//   RESET      synchronous, active-high reset
//   bus        bus_share_arbiter_if.slave (requests, operands, grants, bus)
//   GCOUNT0/1  grant-entry counters, 8-bit saturating; present only when
//              ARB_STATS_EN is defined
//
// Parameters
//   MAX_HOLD   maximum consecutive ownership cycles under contention (1..255)
//
// Optional feature macro: ARB_STATS_EN
module bus_share_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  bus_share_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [7:0]           GCOUNT0,
  output logic [7:0]           GCOUNT1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // HOLD saturates here. Reaching this value while the other side requests
  // releases the bus.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     state;
  state_t     nxt;
  logic       released;
  logic       select_q;
  logic [7:0] hold;
  logic       last;
  logic [7:0] busout_q;
  logic       busvalid_q;
  logic [7:0] sel_data;

`ifdef ARB_STATS_EN
  logic [7:0] gcount0_q;
  logic [7:0] gcount1_q;
`endif

  // In an OWNx state, select_q already points at the owner.
  assign sel_data = select_q ? bus.DATA1 : bus.DATA0;

  always_comb begin
    nxt      = state;
    released = 1'b0;
    case (state)
      IDLE: begin
        if (bus.REQ0 && bus.REQ1) begin
          // Contention from idle goes to whoever did not release last.
          nxt = last ? OWN0 : OWN1;
        end else if (bus.REQ0) begin
          nxt = OWN0;
        end else if (bus.REQ1) begin
          nxt = OWN1;
        end
      end
      OWN0: begin
        if (!bus.REQ0 || (hold == HOLD_LIMIT && bus.REQ1)) begin
          released = 1'b1;
          nxt      = bus.REQ1 ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!bus.REQ1 || (hold == HOLD_LIMIT && bus.REQ0)) begin
          released = 1'b1;
          nxt      = bus.REQ0 ? OWN0 : IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      select_q   <= 1'b0;
      hold       <= 8'h00;
      last       <= 1'b1;
      busout_q   <= 8'h00;
      busvalid_q <= 1'b0;
`ifdef ARB_STATS_EN
      gcount0_q  <= 8'h00;
      gcount1_q  <= 8'h00;
`endif
    end else begin
      state <= nxt;

      // SELECT follows the owner and keeps its last value through IDLE.
      if (nxt == OWN0) begin
        select_q <= 1'b0;
      end else if (nxt == OWN1) begin
        select_q <= 1'b1;
      end

      if (nxt == IDLE || nxt != state) begin
        hold <= 8'h00;
      end else if (hold != HOLD_LIMIT) begin
        hold <= hold + 8'd1;
      end

      if (released) begin
        last <= (state == OWN1);
      end

      // The byte presented during a grant cycle appears on the bus one cycle later.
      if (state == OWN0 || state == OWN1) begin
        busout_q   <= sel_data;
        busvalid_q <= 1'b1;
      end else begin
        busvalid_q <= 1'b0;
      end

`ifdef ARB_STATS_EN
      if (nxt == OWN0 && state != OWN0 && gcount0_q != 8'hFF) begin
        gcount0_q <= gcount0_q + 8'd1;
      end
      if (nxt == OWN1 && state != OWN1 && gcount1_q != 8'hFF) begin
        gcount1_q <= gcount1_q + 8'd1;
      end
`endif
    end
  end

  assign bus.GNT0      = (state == OWN0);
  assign bus.GNT1      = (state == OWN1);
  assign bus.SELECT    = select_q;
  assign bus.BUSOUT    = busout_q;
  assign bus.BUSVALID  = busvalid_q;
  assign bus.state_dbg = state;
  assign bus.hold_dbg  = hold;
  assign bus.last_dbg  = last;

`ifdef ARB_STATS_EN
  assign GCOUNT0 = gcount0_q;
  assign GCOUNT1 = gcount1_q;
`endif

endmodule

// File: tb/tb_bus_share_arbiter.sv
// tb_bus_share_arbiter
// Self-checking bench for bus_share_arbiter. It instantiates two copies, with
// MAX_HOLD=4 and MAX_HOLD=1, which share one stimulus stream. A reference
// model predicts the outputs of both copies every cycle. Directed table
// vectors and hand-written sequences add fixed expectations.
// With ARB_STATS_EN defined, the bench also checks the grant counters.
module tb_bus_share_arbiter;

  localparam int W = 24;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic RESET;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  bus_share_arbiter_if ifa ();
  bus_share_arbiter_if ifb ();

`ifdef ARB_STATS_EN
  logic [7:0] gc0_a, gc1_a, gc0_b, gc1_b;
`endif

  bus_share_arbiter #(.MAX_HOLD(4)) dut (
    .CLK(CLK), .RESET(RESET), .bus(ifa.slave)
`ifdef ARB_STATS_EN
    , .GCOUNT0(gc0_a), .GCOUNT1(gc1_a)
`endif
  );

  bus_share_arbiter #(.MAX_HOLD(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .bus(ifb.slave)
`ifdef ARB_STATS_EN
    , .GCOUNT0(gc0_b), .GCOUNT1(gc1_b)
`endif
  );

  // ---------------- reference model ----------------
  // owner: -1 = nobody. run: number of cycles the current owner has held
  // the bus, counting the current cycle.
  typedef struct {
    int owner;
    int run;
    int last;
    int sel;
    int valid;
    int busv;
    int cnt0;
    int cnt1;
  } mdl_t;

  mdl_t m4, m1;

  function automatic void mdl_step(inout mdl_t m, input bit rst, input bit r0, input bit r1,
                                   input int d0, input int d1, input int maxh);
    int req[2];
    int dat[2];
    int x, y, nw;
    req[0] = r0; req[1] = r1;
    dat[0] = d0; dat[1] = d1;
    if (rst) begin
      m.owner = -1; m.run = 0; m.last = 1; m.sel = 0;
      m.valid = 0; m.busv = 0; m.cnt0 = 0; m.cnt1 = 0;
      return;
    end
    if (m.owner >= 0) begin
      m.busv  = dat[m.owner];
      m.valid = 1;
    end else begin
      m.valid = 0;
    end
    if (m.owner < 0) begin
      if (r0 && r1) nw = 1 - m.last;
      else if (r0)  nw = 0;
      else if (r1)  nw = 1;
      else          nw = -1;
      if (nw >= 0) begin
        m.owner = nw;
        m.run   = 1;
        if (nw == 0) m.cnt0 = (m.cnt0 < 255) ? m.cnt0 + 1 : 255;
        else         m.cnt1 = (m.cnt1 < 255) ? m.cnt1 + 1 : 255;
      end
    end else begin
      x = m.owner;
      y = 1 - x;
      if (req[x] == 0 || (m.run >= maxh && req[y] != 0)) begin
        m.last = x;
        if (req[y] != 0) begin
          m.owner = y;
          m.run   = 1;
          if (y == 0) m.cnt0 = (m.cnt0 < 255) ? m.cnt0 + 1 : 255;
          else        m.cnt1 = (m.cnt1 < 255) ? m.cnt1 + 1 : 255;
        end else begin
          m.owner = -1;
        end
      end else begin
        m.run = m.run + 1;
      end
    end
    if (m.owner >= 0) m.sel = m.owner;
  endfunction

  // Packed view: {state, gnt0, gnt1, sel, valid, last, hold, bus}
  function automatic logic [W-1:0] mdl_pack(input mdl_t m, input int maxh);
    logic [1:0] st;
    logic [7:0] hd;
    st = (m.owner < 0) ? 2'd0 : 2'(m.owner + 1);
    if (m.owner < 0) hd = 8'd0;
    else             hd = 8'((m.run - 1 < maxh - 1) ? m.run - 1 : maxh - 1);
    return {st, 1'(m.owner == 0), 1'(m.owner == 1), 1'(m.sel), 1'(m.valid),
            1'(m.last), hd, 8'(m.busv), 1'b0};
  endfunction

  function automatic logic [W-1:0] dut_pack_a();
    return {ifa.state_dbg, ifa.GNT0, ifa.GNT1, ifa.SELECT, ifa.BUSVALID,
            ifa.last_dbg, ifa.hold_dbg, ifa.BUSOUT, 1'b0};
  endfunction

  function automatic logic [W-1:0] dut_pack_b();
    return {ifb.state_dbg, ifb.GNT0, ifb.GNT1, ifb.SELECT, ifb.BUSVALID,
            ifb.last_dbg, ifb.hold_dbg, ifb.BUSOUT, 1'b0};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit rst, input bit r0, input bit r1,
                      input logic [7:0] d0, input logic [7:0] d1);
    RESET = rst;
    ifa.REQ0 = r0; ifa.REQ1 = r1; ifa.DATA0 = d0; ifa.DATA1 = d1;
    ifb.REQ0 = r0; ifb.REQ1 = r1; ifb.DATA0 = d0; ifb.DATA1 = d1;
    mdl_step(m4, rst, r0, r1, int'(d0), int'(d1), 4);
    exp_q.push_back(mdl_pack(m4, 4));
    mdl_step(m1, rst, r0, r1, int'(d0), int'(d1), 1);
    exp1_q.push_back(mdl_pack(m1, 1));
    @(posedge CLK);
    #1;
    check_val("model_maxhold4", 32'(dut_pack_a()), 32'(exp_q.pop_front()));
    check_val("model_maxhold1", 32'(dut_pack_b()), 32'(exp1_q.pop_front()));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         rst, r0, r1;
    logic [7:0] d0, d1;
    bit         g0, g1, sel, vld, lst;
    logic [7:0] busv;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit r0, input bit r1,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input bit g0, input bit g1, input bit sel,
                              input bit vld, input bit lst, input logic [7:0] busv);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.sel = sel; v.vld = vld; v.lst = lst; v.busv = busv;
    return v;
  endfunction

  vec_t vecs[17];

  initial begin
    int own, prev;
    RESET = 1'b1;
    ifa.REQ0 = 0; ifa.REQ1 = 0; ifa.DATA0 = 0; ifa.DATA1 = 0;
    ifb.REQ0 = 0; ifb.REQ1 = 0; ifb.DATA0 = 0; ifb.DATA1 = 0;

    //             rst r0 r1 d0     d1     g0 g1 sel vld lst bus
    vecs[0]  = mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00);
    vecs[1]  = mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00);
    vecs[2]  = mk(0, 1, 0, 8'hA5, 8'h00, 1, 0, 0, 0, 1, 8'h00);
    vecs[3]  = mk(0, 1, 0, 8'hA5, 8'h00, 1, 0, 0, 1, 1, 8'hA5);
    vecs[4]  = mk(0, 0, 0, 8'hA5, 8'h00, 0, 0, 0, 1, 0, 8'hA5);
    vecs[5]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);
    vecs[6]  = mk(0, 1, 0, 8'h31, 8'h42, 1, 0, 0, 0, 0, 8'hA5);
    vecs[7]  = mk(0, 1, 1, 8'h31, 8'h42, 1, 0, 0, 1, 0, 8'h31);
    vecs[8]  = mk(0, 0, 1, 8'h31, 8'h42, 0, 1, 1, 1, 0, 8'h31);
    vecs[9]  = mk(0, 0, 0, 8'h31, 8'h42, 0, 0, 1, 1, 1, 8'h42);
    vecs[10] = mk(0, 1, 0, 8'h31, 8'h42, 1, 0, 0, 0, 1, 8'h42);
    vecs[11] = mk(0, 0, 0, 8'h31, 8'h42, 0, 0, 0, 1, 0, 8'h31);
    vecs[12] = mk(0, 1, 1, 8'h31, 8'h42, 0, 1, 1, 0, 0, 8'h31);
    vecs[13] = mk(0, 1, 1, 8'h31, 8'h42, 0, 1, 1, 1, 0, 8'h42);
    vecs[14] = mk(1, 1, 1, 8'h31, 8'h42, 0, 0, 0, 0, 1, 8'h00);
    vecs[15] = mk(0, 1, 1, 8'h31, 8'h42, 1, 0, 0, 0, 1, 8'h00);
    vecs[16] = mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00);

    mdl_step(m4, 1'b1, 1'b0, 1'b0, 0, 0, 4);
    mdl_step(m1, 1'b1, 1'b0, 1'b0, 0, 0, 1);

    for (int i = 0; i < 17; i++) begin
      tick(vecs[i].rst, vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1);
      check_val($sformatf("vec%0d_gnt0", i), 32'(ifa.GNT0), 32'(vecs[i].g0));
      check_val($sformatf("vec%0d_gnt1", i), 32'(ifa.GNT1), 32'(vecs[i].g1));
      check_val($sformatf("vec%0d_select", i), 32'(ifa.SELECT), 32'(vecs[i].sel));
      check_val($sformatf("vec%0d_busvalid", i), 32'(ifa.BUSVALID), 32'(vecs[i].vld));
      check_val($sformatf("vec%0d_last", i), 32'(ifa.last_dbg), 32'(vecs[i].lst));
      check_val($sformatf("vec%0d_busout", i), 32'(ifa.BUSOUT), 32'(vecs[i].busv));
    end

    // Sustained contention with MAX_HOLD=4: four cycles each, no idle gap.
    tick(1, 0, 0, 8'h00, 8'h00);
    prev = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(0, 1, 1, 8'h11, 8'h22);
      own = ((k - 1) / 4) % 2;
      check_val($sformatf("contend%0d_gnt0", k), 32'(ifa.GNT0), 32'(own == 0));
      check_val($sformatf("contend%0d_gnt1", k), 32'(ifa.GNT1), 32'(own == 1));
      check_val($sformatf("contend%0d_select", k), 32'(ifa.SELECT), 32'(own));
      if (k >= 2) begin
        check_val($sformatf("contend%0d_busout", k), 32'(ifa.BUSOUT),
                  (prev == 0) ? 32'h11 : 32'h22);
        check_val($sformatf("contend%0d_busvalid", k), 32'(ifa.BUSVALID), 32'd1);
      end
      prev = own;
    end

    // Single requester held: no pre-emption, HOLD saturates at 3.
    tick(1, 0, 0, 8'h00, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      tick(0, 0, 1, 8'h00, 8'h77);
      check_val($sformatf("solo%0d_gnt1", k), 32'(ifa.GNT1), 32'd1);
      check_val($sformatf("solo%0d_hold", k), 32'(ifa.hold_dbg), (k - 1 < 3) ? 32'(k - 1) : 32'd3);
    end

    // Long contention: MAX_HOLD=1 copy alternates every cycle and its counters saturate.
    tick(1, 0, 0, 8'h00, 8'h00);
    for (int k = 1; k <= 600; k++) begin
      tick(0, 1, 1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
`ifdef ARB_STATS_EN
    check_val("gcount0_sat", 32'(gc0_b), 32'hFF);
    check_val("gcount1_sat", 32'(gc1_b), 32'hFF);
    check_val("gcount0_maxhold4", 32'(gc0_a), 32'(m4.cnt0));
    check_val("gcount1_maxhold4", 32'(gc1_a), 32'(m4.cnt1));
`endif

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      tick(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
`ifdef ARB_STATS_EN
    check_val("gcount0_rand", 32'(gc0_a), 32'(m4.cnt0));
    check_val("gcount1_rand", 32'(gc1_a), 32'(m4.cnt1));
    check_val("gcount0_rand_mh1", 32'(gc0_b), 32'(m1.cnt0));
    check_val("gcount1_rand_mh1", 32'(gc1_b), 32'(m1.cnt1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
